// File: rtl/obstacle_scheduler_pkg.sv
// Shared types and helpers for the obstacle scheduler: FSM states, the empty
// type code and modulo-N index stepping that wraps by compare, so any depth works.
package obstacle_scheduler_pkg;

   typedef enum logic [2:0] {
      WAITING,
      RUNNING,
      SPAWN,
      SETTLE,
      RETIRE,
      CRASHED
   } state_t;

   localparam int NONE = 0;

   function automatic int idx_incr(input int idx, input int n);
      return (idx >= n - 1) ? 0 : idx + 1;
   endfunction

   function automatic int idx_decr(input int idx, input int n);
      return (idx == 0) ? n - 1 : idx - 1;
   endfunction

endpackage

// File: rtl/obstacle_scheduler_type_picker.sv
// Combinational type search: walks the rng-rotated candidate list and takes the
// first type that is fast enough and would not extend a run of identical types.
module obstacle_type_picker
   import obstacle_scheduler_pkg::*;
#(
   parameter int TYPE_COUNT = 3,
   parameter int DUP_LIMIT  = 2,
   parameter int TYPE_W     = $clog2(TYPE_COUNT + 1)
) (
   input  logic [TYPE_W-1:0] hist [DUP_LIMIT],
   input  logic              hist_full,
   input  logic [14:0]       speed,
   input  logic [14:0]       min_speed [TYPE_COUNT+1],
   input  logic [10:0]       rng_data,
   output logic [TYPE_W-1:0] pick_type,
   output logic              pick_found
);

   int                cand;
   logic [TYPE_W-1:0] cand_t;
   logic              dup;

   always_comb begin
      cand       = 0;
      cand_t     = '0;
      dup        = 1'b0;
      pick_type  = TYPE_W'(NONE);
      pick_found = 1'b0;
      for (int i = 0; i < TYPE_COUNT; i++) begin
         cand   = ((int'(rng_data) + i) % TYPE_COUNT) + 1;
         cand_t = TYPE_W'(cand);
         // hist_full is low while fewer than DUP_LIMIT entries exist
         dup    = hist_full;
         for (int k = 0; k < DUP_LIMIT; k++) begin
            if (hist[k] != cand_t) dup = 1'b0;
         end
         if (!pick_found && (speed >= min_speed[cand_t]) && !dup) begin
            pick_found = 1'b1;
            pick_type  = cand_t;
         end
      end
   end

endmodule

// File: rtl/obstacle_scheduler.sv
// Circular queue manager for scrolling obstacle slots: spawns, types and retires.
// Define OBSTACLE_SCHEDULER_MULTI_RETIRE_EN to retire a whole removable run per update.
module obstacle_scheduler
   import obstacle_scheduler_pkg::*;
#(
   parameter int N_SLOTS    = 7,
   parameter int TYPE_COUNT = 3,
   parameter int DUP_LIMIT  = 2,
   parameter int GAME_WIDTH = 640,
   parameter int IDX_W      = $clog2(N_SLOTS),
   parameter int TYPE_W     = $clog2(TYPE_COUNT + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                update,
   input  logic                start,
   input  logic                crash,
   input  logic                restart,
   input  logic                spawn_en,
   input  logic [14:0]         speed,
   input  logic [14:0]         min_speed [TYPE_COUNT+1],
   input  logic [10:0]         rng_data,
   input  logic signed [10:0]  slot_x_pos [N_SLOTS],
   input  logic [9:0]          slot_width [N_SLOTS],
   input  logic [10:0]         slot_gap [N_SLOTS],
   input  logic [N_SLOTS-1:0]  slot_visible,
   input  logic [N_SLOTS-1:0]  slot_remove,
   output logic                slot_update,
   output logic [N_SLOTS-1:0]  slot_start,
   output logic [TYPE_W-1:0]   slot_type [N_SLOTS],
   output logic [IDX_W-1:0]    front_idx,
   output logic                front_valid,
   output logic [IDX_W:0]      count,
   output logic                spawn_blocked,
   output state_t              state_dbg
);

`ifdef OBSTACLE_SCHEDULER_MULTI_RETIRE_EN
   localparam int RETIRE_MAX = N_SLOTS;
`else
   localparam int RETIRE_MAX = 1;
`endif

   localparam logic [IDX_W:0]     FULL = (IDX_W + 1)'(N_SLOTS);
   localparam logic signed [12:0] GW_S = 13'(GAME_WIDTH);

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    front_q, front_d;
   logic [IDX_W-1:0]    back_q, back_d;
   logic [IDX_W:0]      count_q, count_d;
   logic [N_SLOTS-1:0]  start_q, start_d;
   logic [TYPE_W-1:0]   type_q [N_SLOTS];
   logic [TYPE_W-1:0]   type_d [N_SLOTS];
   logic [IDX_W-1:0]    front_idx_q, front_idx_d;
   logic                front_valid_q, front_valid_d;

   logic                slot_update_c, blocked_c;
   logic [IDX_W-1:0]    last_idx;
   logic signed [12:0]  thr_sum;
   logic                spawn_want;
   logic [TYPE_W-1:0]   hist [DUP_LIMIT];
   logic                hist_full;
   logic [TYPE_W-1:0]   pick_type;
   logic                pick_found;
   int                  hist_j;
   int                  ret_idx, ret_cnt;
   logic                ret_stop;

   // Newest entry sits one behind back; the threshold test looks at its right edge plus gap.
   assign last_idx = IDX_W'(idx_decr(int'(back_q), N_SLOTS));
   assign thr_sum  = {{2{slot_x_pos[last_idx][10]}}, slot_x_pos[last_idx]}
                   + {3'b000, slot_width[last_idx]}
                   + {2'b00, slot_gap[last_idx]};
   assign spawn_want = spawn_en &&
                       ((count_q == '0) || (slot_visible[last_idx] && (thr_sum < GW_S)));

   always_comb begin
      hist_j = int'(back_q);
      for (int k = 0; k < DUP_LIMIT; k++) begin
         hist_j  = idx_decr(hist_j, N_SLOTS);
         hist[k] = type_q[IDX_W'(hist_j)];
      end
   end

   assign hist_full = int'(count_q) >= DUP_LIMIT;

   obstacle_type_picker #(
      .TYPE_COUNT (TYPE_COUNT),
      .DUP_LIMIT  (DUP_LIMIT),
      .TYPE_W     (TYPE_W)
   ) u_picker (
      .hist       (hist),
      .hist_full  (hist_full),
      .speed      (speed),
      .min_speed  (min_speed),
      .rng_data   (rng_data),
      .pick_type  (pick_type),
      .pick_found (pick_found)
   );

   always_comb begin
      state_d       = state_q;
      front_d       = front_q;
      back_d        = back_q;
      count_d       = count_q;
      start_d       = start_q;
      type_d        = type_q;
      front_idx_d   = front_q;
      front_valid_d = (count_q != '0);
      slot_update_c = 1'b0;
      blocked_c     = 1'b0;
      ret_idx       = int'(front_q);
      ret_cnt       = int'(count_q);
      ret_stop      = 1'b0;
      if (restart) begin
         state_d       = WAITING;
         front_d       = '0;
         back_d        = '0;
         count_d       = '0;
         start_d       = '0;
         type_d        = '{default: TYPE_W'(NONE)};
         front_idx_d   = '0;
         front_valid_d = 1'b0;
      end else begin
         case (state_q)
            WAITING: if (start) state_d = RUNNING;
            RUNNING: begin
               if (crash)       state_d = CRASHED;
               else if (update) state_d = SPAWN;
            end
            SPAWN: begin
               slot_update_c = 1'b1;
               state_d       = SETTLE;
               if (spawn_want) begin
                  if (count_q == FULL) begin
                     blocked_c = 1'b1;
                  end else if (pick_found) begin
                     type_d[back_q]  = pick_type;
                     start_d[back_q] = 1'b1;
                     back_d          = IDX_W'(idx_incr(int'(back_q), N_SLOTS));
                     count_d         = count_q + (IDX_W + 1)'(1);
                  end
               end
            end
            SETTLE: state_d = RETIRE;
            RETIRE: begin
               // Walk forward from front while slots keep reporting removable.
               for (int k = 0; k < RETIRE_MAX; k++) begin
                  if (!ret_stop && (ret_cnt != 0) && slot_remove[IDX_W'(ret_idx)]) begin
                     start_d[IDX_W'(ret_idx)] = 1'b0;
                     ret_idx = idx_incr(ret_idx, N_SLOTS);
                     ret_cnt = ret_cnt - 1;
                  end else begin
                     ret_stop = 1'b1;
                  end
               end
               front_d = IDX_W'(ret_idx);
               count_d = (IDX_W + 1)'(ret_cnt);
               state_d = RUNNING;
            end
            CRASHED: state_d = CRASHED;
            default: state_d = WAITING;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= WAITING;
         front_q       <= '0;
         back_q        <= '0;
         count_q       <= '0;
         start_q       <= '0;
         type_q        <= '{default: TYPE_W'(NONE)};
         front_idx_q   <= '0;
         front_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         front_q       <= front_d;
         back_q        <= back_d;
         count_q       <= count_d;
         start_q       <= start_d;
         type_q        <= type_d;
         front_idx_q   <= front_idx_d;
         front_valid_q <= front_valid_d;
      end
   end

   assign slot_update   = slot_update_c;
   assign spawn_blocked = blocked_c;
   assign slot_start    = start_q;
   assign slot_type     = type_q;
   assign front_idx     = front_idx_q;
   assign front_valid   = front_valid_q;
   assign count         = count_q;
   assign state_dbg     = state_q;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Directed bench for obstacle_scheduler: queue-based reference model checked every
// cycle, plus hand-computed expectations at key points of the scenario.
module tb_obstacle_scheduler;
   import obstacle_scheduler_pkg::*;

   localparam int N   = 7;
   localparam int TC  = 3;
   localparam int DUP = 2;
   localparam int GW  = 640;
   localparam int IW  = $clog2(N);
   localparam int TW  = $clog2(TC + 1);
`ifdef OBSTACLE_SCHEDULER_MULTI_RETIRE_EN
   localparam int RET_LIM = N;
`else
   localparam int RET_LIM = 1;
`endif

   logic               clk = 1'b0;
   logic               rst, update, start, crash, restart, spawn_en;
   logic [14:0]        speed;
   logic [14:0]        min_speed [TC+1];
   logic [10:0]        rng_data;
   logic signed [10:0] x_pos [N];
   logic [9:0]         width [N];
   logic [10:0]        gap [N];
   logic [N-1:0]       visible, remove;
   logic               slot_update;
   logic [N-1:0]       slot_start;
   logic [TW-1:0]      slot_type [N];
   logic [IW-1:0]      front_idx;
   logic               front_valid;
   logic [IW:0]        count;
   logic               spawn_blocked;
   state_t             state_dbg;

   int vectors = 0;
   int miscompares = 0;
   bit check_en = 1'b0;

   always #5 clk = ~clk;

   obstacle_scheduler #(.N_SLOTS(N), .TYPE_COUNT(TC), .DUP_LIMIT(DUP), .GAME_WIDTH(GW)) dut (
      .clk (clk), .rst (rst), .update (update), .start (start), .crash (crash),
      .restart (restart), .spawn_en (spawn_en), .speed (speed), .min_speed (min_speed),
      .rng_data (rng_data), .slot_x_pos (x_pos), .slot_width (width), .slot_gap (gap),
      .slot_visible (visible), .slot_remove (remove), .slot_update (slot_update),
      .slot_start (slot_start), .slot_type (slot_type), .front_idx (front_idx),
      .front_valid (front_valid), .count (count), .spawn_blocked (spawn_blocked),
      .state_dbg (state_dbg)
   );

   // Reference model: occupied slots in age order plus their types.
   state_t        m_phase;
   int            occ_q[$];
   logic [TW-1:0] exp_q[$];
   int            m_back;
   int            m_type [N];
   bit            m_start [N];
   int            m_fidx;
   bit            m_fvalid;

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int m_front();
      return (m_back - occ_q.size() + N) % N;
   endfunction

   function automatic bit m_want();
      int last;
      if (!spawn_en) return 1'b0;
      if (occ_q.size() == 0) return 1'b1;
      last = occ_q[occ_q.size() - 1];
      if (!visible[last]) return 1'b0;
      return (int'(x_pos[last]) + int'(width[last]) + int'(gap[last])) < GW;
   endfunction

   function automatic int m_pick();
      int c;
      bit dup;
      int sz;
      sz = exp_q.size();
      for (int i = 0; i < TC; i++) begin
         c = ((int'(rng_data) + i) % TC) + 1;
         if (speed < min_speed[c]) continue;
         dup = (sz >= DUP);
         for (int k = 1; k <= DUP; k++) begin
            if (dup && int'(exp_q[sz - k]) != c) dup = 1'b0;
         end
         if (!dup) return c;
      end
      return 0;
   endfunction

   task automatic model_reset();
      m_phase = WAITING;
      occ_q.delete();
      exp_q.delete();
      m_back = 0;
      for (int i = 0; i < N; i++) begin
         m_type[i]  = 0;
         m_start[i] = 1'b0;
      end
      m_fidx   = 0;
      m_fvalid = 1'b0;
   endtask

   task automatic model_step();
      int t;
      int n;
      if (restart) begin
         model_reset();
      end else begin
         m_fidx   = m_front();
         m_fvalid = (occ_q.size() != 0);
         case (m_phase)
            WAITING: if (start) m_phase = RUNNING;
            RUNNING: begin
               if (crash)       m_phase = CRASHED;
               else if (update) m_phase = SPAWN;
            end
            SPAWN: begin
               if (m_want() && occ_q.size() < N) begin
                  t = m_pick();
                  if (t != 0) begin
                     m_type[m_back]  = t;
                     m_start[m_back] = 1'b1;
                     occ_q.push_back(m_back);
                     exp_q.push_back(TW'(t));
                     m_back = (m_back + 1) % N;
                  end
               end
               m_phase = SETTLE;
            end
            SETTLE: m_phase = RETIRE;
            RETIRE: begin
               n = 0;
               while (occ_q.size() != 0 && remove[occ_q[0]] && n < RET_LIM) begin
                  m_start[occ_q[0]] = 1'b0;
                  void'(occ_q.pop_front());
                  void'(exp_q.pop_front());
                  n++;
               end
               m_phase = RUNNING;
            end
            default: ;
         endcase
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) model_reset();
      else     model_step();
   end

   always @(negedge clk) begin
      if (check_en) begin
         check("state", int'(state_dbg), int'(m_phase));
         check("slot_update", slot_update, m_phase == SPAWN && !restart);
         check("spawn_blocked", spawn_blocked,
               m_phase == SPAWN && !restart && m_want() && occ_q.size() == N);
         check("count", count, occ_q.size());
         check("front_idx", front_idx, m_fidx);
         check("front_valid", front_valid, m_fvalid);
         for (int i = 0; i < N; i++) begin
            check("slot_start", slot_start[i], m_start[i]);
            check("slot_type", slot_type[i], m_type[i]);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_update(output logic su, output logic sb);
      update = 1'b1;
      tick(1);
      update = 1'b0;
      su = slot_update;
      sb = spawn_blocked;
      tick(3);
      check("run_after_4", int'(state_dbg), int'(RUNNING));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic su, sb;
      rst = 1'b1; update = 1'b0; start = 1'b0; crash = 1'b0; restart = 1'b0;
      spawn_en = 1'b0; speed = 15'd600; rng_data = '0;
      visible = '1; remove = '0;
      for (int i = 0; i <= TC; i++) min_speed[i] = '0;
      for (int i = 0; i < N; i++) begin
         x_pos[i] = '0; width[i] = '0; gap[i] = '0;
      end
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_en = 1'b1;
      tick(1);
      check("reset_count", count, 0);
      check("reset_start", slot_start, 0);
      check("reset_front_valid", front_valid, 0);
      rst = 1'b0;
      tick(1);

      start = 1'b1; tick(1); start = 1'b0;
      check("start_running", int'(state_dbg), int'(RUNNING));

      // First spawn into an empty queue, rng 5 -> type 3.
      spawn_en = 1'b1; rng_data = 11'd5;
      do_update(su, sb);
      check("first_slot_update", su, 1);
      check("first_type", slot_type[0], 3);
      check("first_count", count, 1);

      // Threshold: 500+50+100 = 650 blocks, 480+50+100 = 630 spawns.
      x_pos[0] = 11'sd500; width[0] = 10'd50; gap[0] = 11'd100; rng_data = 11'd0;
      do_update(su, sb);
      check("thr_650_count", count, 1);
      x_pos[0] = 11'sd480;
      do_update(su, sb);
      check("thr_630_count", count, 2);
      check("thr_630_type", slot_type[1], 1);
      x_pos[0] = '0; width[0] = '0; gap[0] = '0;

      // Build history (2,2) then the duplicate rule forces type 3.
      rng_data = 11'd1;
      do_update(su, sb);
      do_update(su, sb);
      do_update(su, sb);
      check("dup_type", slot_type[4], 3);
      do_update(su, sb);
      do_update(su, sb);
      check("full_count", count, 7);

      do_update(su, sb);
      check("blocked_pulse", sb, 1);
      check("blocked_count", count, 7);

      remove[0] = 1'b1;
      do_update(su, sb);
      check("retire_count", count, 6);
      check("front_idx_lag", front_idx, 0);
      tick(1);
      check("front_idx_after", front_idx, 1);
      remove[0] = 1'b0;

      // Dup blocks 2, speed blocks 3, so type 1 lands in wrapped slot 0.
      min_speed[3] = 15'd900;
      do_update(su, sb);
      check("speed_type", slot_type[0], 1);
      check("wrap_count", count, 7);
      check("wrap_start", slot_start[0], 1);
      min_speed[3] = '0;

      spawn_en = 1'b0;
      remove[1] = 1'b1; remove[2] = 1'b1;
      do_update(su, sb);
`ifdef OBSTACLE_SCHEDULER_MULTI_RETIRE_EN
      check("multi_retire_1", count, 5);
`else
      check("multi_retire_1", count, 6);
`endif
      do_update(su, sb);
      check("multi_retire_2", count, 5);
      for (int i = 3; i < N; i++) remove[i] = 1'b1;
      repeat (4) do_update(su, sb);
      check("front_wrap_count", count, 1);
      tick(1);
      check("front_wrap_idx", front_idx, 0);
      remove = '0;

      crash = 1'b1; update = 1'b1;
      tick(1);
      update = 1'b0;
      check("crash_no_update", slot_update, 0);
      check("crash_state", int'(state_dbg), int'(CRASHED));
      tick(3);
      crash = 1'b0;
      update = 1'b1; tick(1); update = 1'b0;
      tick(2);
      check("crash_holds", int'(state_dbg), int'(CRASHED));

      restart = 1'b1; tick(1); restart = 1'b0;
      check("restart_state", int'(state_dbg), int'(WAITING));
      check("restart_count", count, 0);

      start = 1'b1; tick(1); start = 1'b0;
      spawn_en = 1'b1; rng_data = 11'd2;
      update = 1'b1; tick(1); update = 1'b0;
      tick(1);
      check("settle_count", count, 1);
      restart = 1'b1; tick(1); restart = 1'b0;
      check("settle_restart_state", int'(state_dbg), int'(WAITING));
      check("settle_restart_start", slot_start, 0);
      check("settle_restart_count", count, 0);

      start = 1'b1; tick(1); start = 1'b0;
      do_update(su, sb);
      check("pre_rst_count", count, 1);
      update = 1'b1; tick(1); update = 1'b0;
      check("pre_rst_spawn", slot_update, 1);
      #2;
      rst = 1'b1;
      #1;
      check("arst_count", count, 0);
      check("arst_start", slot_start, 0);
      check("arst_type0", slot_type[0], 0);
      check("arst_update", slot_update, 0);
      check("arst_state", int'(state_dbg), int'(WAITING));
      tick(1);
      rst = 1'b0;
      tick(2);

      check_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/obstacle_scheduler.md
Name: obstacle_scheduler

Overview:
- Parametrised queue manager for scrolling obstacles: spawns, types and retires up to N_SLOTS externally instantiated obstacle slots.
- Sits between the game controller and the obstacle slot array. Drives slot start/type/update and reports the front (leftmost) slot for collision selection.
- Successor to the fixed-depth scheduler: any depth (not only 2^k), explicit occupancy count (a full queue is legal), configurable type count and duplication limit, restart without reset.

Parameters:
- N_SLOTS, 7, number of obstacle slots (2..32)
- TYPE_COUNT, 3, spawnable types; codes 1..TYPE_COUNT, code 0 = NONE
- DUP_LIMIT, 2, maximum consecutive identical types
- GAME_WIDTH, 640, spawn threshold in pixels
- IDX_W, $clog2(N_SLOTS), slot index width
- TYPE_W, $clog2(TYPE_COUNT+1), type code width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- update  in  1  one-cycle frame tick
- start  in  1  leave WAITING
- crash  in  1  level; game crashed
- restart  in  1  pulse; clear queue, return to WAITING
- spawn_en  in  1  allow new obstacles
- speed  in  15  current speed
- min_speed  in  [TYPE_COUNT+1][15]  per-type minimum speed
- rng_data  in  11  random source
- slot_x_pos  in  [N_SLOTS] signed 11  slot left edge
- slot_width  in  [N_SLOTS] 10  slot width
- slot_gap  in  [N_SLOTS] 11  gap requested after slot
- slot_visible  in  [N_SLOTS] 1  slot on screen
- slot_remove  in  [N_SLOTS] 1  slot scrolled off
- slot_update  out  1  one-cycle update to all slots
- slot_start  out  [N_SLOTS] 1  slot active
- slot_type  out  [N_SLOTS] TYPE_W  slot type
- front_idx  out  IDX_W  oldest occupied slot, registered
- front_valid  out  1  count != 0, registered
- count  out  IDX_W+1  occupancy
- spawn_blocked  out  1  pulse; spawn wanted but queue full

Behaviour:
- States: WAITING, RUNNING, SPAWN, SETTLE, RETIRE, CRASHED.
- Transitions:
  - WAITING -> RUNNING on start.
  - RUNNING: crash -> CRASHED (crash has priority); else update -> SPAWN.
  - SPAWN -> SETTLE -> RETIRE -> RUNNING unconditionally.
  - CRASHED holds.
  - restart from any state: -> WAITING, same clearing as reset except the asynchronous path.
- update during SPAWN/SETTLE/RETIRE is ignored. crash during those states is evaluated on return to RUNNING.
- Reset/restart values: all outputs 0; front, back, count = 0; slot_type = NONE.
- Queue: front/back wrap modulo N_SLOTS via compare, not bit truncation. count distinguishes full from empty.
- SPAWN cycle:
  - slot_update = 1 for exactly this cycle.
  - Empty: spawn if spawn_en.
  - Non-empty: last = back-1 mod N. Spawn if spawn_en && slot_visible[last] && x_pos + width + gap < GAME_WIDTH.
  - Threshold sum computed in 13-bit signed; width and gap zero-extended.
  - Spawn when count == N_SLOTS: no spawn, spawn_blocked = 1 for one cycle.
  - Spawn: slot_type[back] = chosen type, slot_start[back] = 1, back++, count++.
- Type choice: for i = 0..TYPE_COUNT-1, candidate = ((rng_data + i) mod TYPE_COUNT) + 1.
  - Accept the first candidate whose speed >= min_speed[candidate] and which is not a duplicate.
  - Duplicate: the last DUP_LIMIT occupied entries all equal the candidate. Fewer than DUP_LIMIT occupied entries never counts as duplicate.
  - No candidate accepted: no spawn, no pulse.
- SETTLE: slot_update = 0; slots compute.
- RETIRE: if count != 0 && slot_remove[front]: slot_start[front] = 0, front++, count--.
- front_idx/front_valid registered every cycle from the current front/count (one-cycle lag).
- Spawn and retire never occur in the same cycle.

Optional Feature:
- OBSTACLE_SCHEDULER_MULTI_RETIRE_EN.
- Defined: RETIRE removes the whole run of consecutive removable slots from front, bounded by count, in one cycle.
- Undefined: at most one slot retired per update.

Decomposition:
- scheduler_pkg: state_t, NONE type code, index incr/decr wrap functions.
- Sub-module obstacle_type_picker: combinational candidate search (type history window, speed, rng in; type and found out).

Test Plan:
- Empty, spawn_en = 1, rng = 5, TYPE_COUNT = 3, min_speed all 0, update -> SPAWN cycle: slot 0 type 3, count = 1, slot_update high exactly 1 cycle, RUNNING after 4 cycles.
- Last slot x = 500, width = 50, gap = 100 (sum 650) -> no spawn. Change x to 480 (sum 630) -> spawn next update.
- History (2, 2), rng picks 2 -> type 3 chosen. min_speed[3] = 900, speed = 600 -> type 1.
- Fill N = 7 slots, spawn condition true -> spawn_blocked pulse, count stays 7. Retire slot 0 -> count 6, front_idx = 1 one cycle later, wraps 6 -> 0.
- slot_remove on fronts 0 and 1 -> one retire per update without macro, both in one RETIRE with macro.
- crash coincident with update in RUNNING -> CRASHED, no slot_update. restart mid-SETTLE -> WAITING, all slot_start = 0, count = 0. Async rst mid-SPAWN clears immediately.
